mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single unified memory port of the multicycle CPU between two requesters. The CPU side is driven by the microprogrammed controller's MemRead/MemWrite and IorD-selected address. The DMA/debug side is a loader or monitor port. The block owns the memory handshake: it arbitrates, registers and issues one access at a time, waits a fixed memory latency, then returns read data with a one-cycle ready pulse. The controller holds its microstate while cpu_ready is low.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, memory cycles from issue to valid mem_rdata (legal range 1..15)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
cpu_req  input  1  CPU access request (MemRead|MemWrite), held until cpu_ready
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  ADDR_W  CPU address
cpu_wdata  input  DATA_W  CPU write data
cpu_rdata  output  DATA_W  CPU read data, registered, holds until the next CPU read completes
cpu_ready  output  1  one-cycle completion pulse to CPU
dma_req, dma_we, dma_addr, dma_wdata  input  1/1/ADDR_W/DATA_W  same semantics, DMA side
dma_rdata  output  DATA_W  DMA read data, registered
dma_ready  output  1  one-cycle completion pulse to DMA
mem_en  output  1  memory access active
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  registered memory address
mem_wdata  output  DATA_W  registered memory write data
mem_rdata  input  DATA_W  memory read data
grant_o  output  2  current owner: 00 none, 01 CPU, 10 DMA

Behaviour:
- Reset (async, immediate):
  - state=IDLE, last_grant=DMA (so the CPU wins the first tie).
  - All outputs 0; cpu_rdata/dma_rdata=0; counter=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any req is high, pick the owner.
    - Only one requester: that requester wins.
    - Both: round-robin, i.e. the requester that is not last_grant wins.
  - At the clock edge: latch owner, we, addr and wdata into mem_* registers; set last_grant=owner; load counter=MEM_LAT-1; go to BUSY.
  - No request: stay in IDLE.
- BUSY:
  - mem_en=1 and mem_we=latched we; mem_addr/mem_wdata are stable for the whole state.
  - grant_o=owner.
  - When counter==0: if the access is a read, capture mem_rdata into the owner's rdata register; go to DONE. Otherwise decrement the counter.
- DONE:
  - mem_en=0 and mem_we=0; the owner's ready=1 for exactly this cycle; grant_o still shows the owner.
  - Next state is IDLE.
  - Requests are ignored in DONE, so a requester that advances on this edge presents a fresh request in IDLE.
- Latency: a request seen in cycle 0 gives BUSY in cycles 1..MEM_LAT and ready in cycle MEM_LAT+1. Throughput is one access per MEM_LAT+2 cycles.
- Non-owner ready is always 0.
- Writes never modify either rdata register.
- Request dropped during BUSY: the access still completes and ready still pulses. This is defined behaviour, not an error.
- Address/data changing during BUSY has no effect, because the values were latched in IDLE.
- MEM_LAT=1: BUSY lasts exactly one cycle.
- rst asserted mid-BUSY or mid-DONE: the access is abandoned and no ready pulse is issued. After release, the CPU wins the next tie.

Optional Feature:
ARB_FIXED_PRIO_EN
- Defined: fixed priority, where the CPU always wins when both requesters are high; the DMA is granted only when cpu_req=0 in IDLE. last_grant is still updated but ignored.
- Undefined: round-robin as described above.

Test Plan:
- MEM_LAT=2, reset, then cpu_req=1, cpu_we=0, cpu_addr=0x10; memory model returns 0xDEADBEEF -> mem_en high in cycles 1-2 with mem_addr=0x10; cpu_ready pulses in cycle 3; cpu_rdata=0xDEADBEEF; dma_ready stays 0.
- DMA write dma_addr=0x20, dma_wdata=0x12345678 -> mem_we=mem_en=1 for 2 cycles; mem_wdata=0x12345678; dma_ready pulses in cycle 3; dma_rdata unchanged.
- Both requesters held high from reset -> grant_o sequence 01,10,01,10; ready pulses at cycles 3(CPU), 7(DMA), 11(CPU), 15(DMA).
- cpu_addr changed to 0x44 during BUSY of an access to 0x10 -> mem_addr stays 0x10; data returned is for 0x10.
- rst pulsed in cycle 2 of a CPU read -> all outputs 0 immediately, no cpu_ready; after release, a simultaneous request grants the CPU first.
- ARB_FIXED_PRIO_EN defined, both requesters held high for 12 cycles -> CPU granted three times, DMA never; when cpu_req drops, the DMA is granted in the next IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Memory-port bundle shared by the CPU, DMA and memory sides of mem_port_arbiter.
// slave = arbiter view; master = environment view (requesters plus memory).
`timescale 1ns/1ps
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        grant_o;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ready, dma_rdata, dma_ready,
    output mem_en, mem_we, mem_addr, mem_wdata, grant_o
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ready, dma_rdata, dma_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata, grant_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU/DMA) arbiter for the single memory port: one access at a time, fixed latency.
// Define ARB_FIXED_PRIO_EN for CPU-first fixed priority; default is round-robin on ties.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input logic            clk,
  input logic            rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CNT_W    = 4;
  localparam logic [1:0]  GNT_NONE = 2'b00;
  localparam logic [1:0]  GNT_CPU  = 2'b01;
  localparam logic [1:0]  GNT_DMA  = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic              last_dma_q, last_dma_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        grant_q, grant_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic              dma_ready_q, dma_ready_d;
  logic              pick_dma_c;

  // DMA wins only when it is alone, or on a tie when the CPU had the last grant
`ifdef ARB_FIXED_PRIO_EN
  assign pick_dma_c = bus.dma_req & ~bus.cpu_req;
`else
  assign pick_dma_c = bus.dma_req & (~bus.cpu_req | ~last_dma_q);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_dma_q  <= 1'b1;
      cnt_q       <= '0;
      grant_q     <= GNT_NONE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_dma_q  <= last_dma_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      dma_ready_q <= dma_ready_d;
    end
  end

  // Next state plus next value of every registered output
  always_comb begin
    state_d     = state_q;
    last_dma_d  = last_dma_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    cpu_ready_d = 1'b0;
    dma_ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = GNT_NONE;
        if (bus.cpu_req | bus.dma_req) begin
          state_d    = BUSY;
          grant_d    = pick_dma_c ? GNT_DMA : GNT_CPU;
          last_dma_d = pick_dma_c;
          mem_en_d   = 1'b1;
          mem_we_d   = pick_dma_c ? bus.dma_we    : bus.cpu_we;
          addr_d     = pick_dma_c ? bus.dma_addr  : bus.cpu_addr;
          wdata_d    = pick_dma_c ? bus.dma_wdata : bus.cpu_wdata;
          cnt_d      = CNT_W'(MEM_LAT - 1);
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!mem_we_q) begin
            if (grant_q == GNT_CPU) cpu_rdata_d = bus.mem_rdata;
            else                    dma_rdata_d = bus.mem_rdata;
          end
          cpu_ready_d = (grant_q == GNT_CPU);
          dma_ready_d = (grant_q == GNT_DMA);
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          mem_en_d = 1'b1;
          mem_we_d = mem_we_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.dma_ready = dma_ready_q;
  assign bus.grant_o   = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand sequences for
// ties, reset mid-access and MEM_LAT=1. Honours ARB_FIXED_PRIO_EN when defined.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MEM_LAT = 2;

  localparam logic [31:0] DB  = 32'hDEADBEEF;
  localparam logic [31:0] R30 = 32'hA5A5A595;
  localparam logic [31:0] R44 = 32'h44444444;
  localparam logic [31:0] W1  = 32'h12345678;
  localparam logic [31:0] W2  = 32'hCAFEF00D;
  localparam logic [31:0] Z   = 32'h0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  // Memory model: data valid only in the last BUSY cycle, garbage otherwise
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h10:  return DB;
      32'h44:  return R44;
      default: return a ^ 32'hA5A5A5A5;
    endcase
  endfunction

  int en_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst)              en_cnt <= 0;
    else if (!bus.mem_en) en_cnt <= 0;
    else                  en_cnt <= en_cnt + 1;
  end
  assign bus.mem_rdata  = (bus.mem_en && en_cnt == int'(MEM_LAT) - 1) ? mem_model(bus.mem_addr) : 32'hBAD0BAD0;
  assign bus1.mem_rdata = bus1.mem_en ? mem_model(bus1.mem_addr) : 32'hBAD0BAD0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic c_req, c_we; logic [31:0] c_addr, c_wd;
    logic d_req, d_we; logic [31:0] d_addr, d_wd;
    logic e_en, e_we; logic [31:0] e_addr, e_wd;
    logic [1:0] e_gnt; logic e_crdy, e_drdy; logic [31:0] e_crd, e_drd;
  } vec_t;

  vec_t vt [24];

  task automatic drive(input logic c_req, c_we, input logic [31:0] c_addr, c_wd,
                       input logic d_req, d_we, input logic [31:0] d_addr, d_wd);
    bus.cpu_req = c_req; bus.cpu_we = c_we; bus.cpu_addr = c_addr; bus.cpu_wdata = c_wd;
    bus.dma_req = d_req; bus.dma_we = d_we; bus.dma_addr = d_addr; bus.dma_wdata = d_wd;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".mem_en"},    32'(bus.mem_en),    Z);
    chk({tag, ".mem_we"},    32'(bus.mem_we),    Z);
    chk({tag, ".mem_addr"},  bus.mem_addr,       Z);
    chk({tag, ".mem_wdata"}, bus.mem_wdata,      Z);
    chk({tag, ".grant"},     32'(bus.grant_o),   Z);
    chk({tag, ".cpu_ready"}, 32'(bus.cpu_ready), Z);
    chk({tag, ".dma_ready"}, 32'(bus.dma_ready), Z);
    chk({tag, ".cpu_rdata"}, bus.cpu_rdata,      Z);
    chk({tag, ".dma_rdata"}, bus.dma_rdata,      Z);
  endtask

  initial begin
    int n_cyc;
    logic [1:0] own;
    int ph;

    vt = '{
      // CPU read 0x10
      '{1'b1,1'b0,32'h10,Z, 1'b0,1'b0,Z,Z,  1'b1,1'b0,32'h10,Z, 2'b01,1'b0,1'b0,Z,Z},
      '{1'b1,1'b0,32'h10,Z, 1'b0,1'b0,Z,Z,  1'b1,1'b0,32'h10,Z, 2'b01,1'b0,1'b0,Z,Z},
      '{1'b1,1'b0,32'h10,Z, 1'b0,1'b0,Z,Z,  1'b0,1'b0,32'h10,Z, 2'b01,1'b1,1'b0,DB,Z},
      '{1'b0,1'b0,Z,Z,      1'b0,1'b0,Z,Z,  1'b0,1'b0,32'h10,Z, 2'b00,1'b0,1'b0,DB,Z},
      // DMA write 0x20
      '{1'b0,1'b0,Z,Z, 1'b1,1'b1,32'h20,W1,  1'b1,1'b1,32'h20,W1, 2'b10,1'b0,1'b0,DB,Z},
      '{1'b0,1'b0,Z,Z, 1'b1,1'b1,32'h20,W1,  1'b1,1'b1,32'h20,W1, 2'b10,1'b0,1'b0,DB,Z},
      '{1'b0,1'b0,Z,Z, 1'b1,1'b1,32'h20,W1,  1'b0,1'b0,32'h20,W1, 2'b10,1'b0,1'b1,DB,Z},
      '{1'b0,1'b0,Z,Z, 1'b0,1'b0,Z,Z,        1'b0,1'b0,32'h20,W1, 2'b00,1'b0,1'b0,DB,Z},
      // DMA read 0x30
      '{1'b0,1'b0,Z,Z, 1'b1,1'b0,32'h30,Z,  1'b1,1'b0,32'h30,Z, 2'b10,1'b0,1'b0,DB,Z},
      '{1'b0,1'b0,Z,Z, 1'b1,1'b0,32'h30,Z,  1'b1,1'b0,32'h30,Z, 2'b10,1'b0,1'b0,DB,Z},
      '{1'b0,1'b0,Z,Z, 1'b1,1'b0,32'h30,Z,  1'b0,1'b0,32'h30,Z, 2'b10,1'b0,1'b1,DB,R30},
      '{1'b0,1'b0,Z,Z, 1'b0,1'b0,Z,Z,       1'b0,1'b0,32'h30,Z, 2'b00,1'b0,1'b0,DB,R30},
      // CPU read 0x44
      '{1'b1,1'b0,32'h44,Z, 1'b0,1'b0,Z,Z,  1'b1,1'b0,32'h44,Z, 2'b01,1'b0,1'b0,DB,R30},
      '{1'b1,1'b0,32'h44,Z, 1'b0,1'b0,Z,Z,  1'b1,1'b0,32'h44,Z, 2'b01,1'b0,1'b0,DB,R30},
      '{1'b1,1'b0,32'h44,Z, 1'b0,1'b0,Z,Z,  1'b0,1'b0,32'h44,Z, 2'b01,1'b1,1'b0,R44,R30},
      '{1'b0,1'b0,Z,Z,      1'b0,1'b0,Z,Z,  1'b0,1'b0,32'h44,Z, 2'b00,1'b0,1'b0,R44,R30},
      // CPU read 0x10, address changed then request dropped during BUSY
      '{1'b1,1'b0,32'h10,Z,     1'b0,1'b0,Z,Z,  1'b1,1'b0,32'h10,Z, 2'b01,1'b0,1'b0,R44,R30},
      '{1'b1,1'b0,32'h44,32'h99,1'b0,1'b0,Z,Z,  1'b1,1'b0,32'h10,Z, 2'b01,1'b0,1'b0,R44,R30},
      '{1'b0,1'b0,32'h44,32'h99,1'b0,1'b0,Z,Z,  1'b0,1'b0,32'h10,Z, 2'b01,1'b1,1'b0,DB,R30},
      '{1'b0,1'b0,Z,Z,          1'b0,1'b0,Z,Z,  1'b0,1'b0,32'h10,Z, 2'b00,1'b0,1'b0,DB,R30},
      // CPU write 0x50 leaves both rdata registers alone
      '{1'b1,1'b1,32'h50,W2, 1'b0,1'b0,Z,Z,  1'b1,1'b1,32'h50,W2, 2'b01,1'b0,1'b0,DB,R30},
      '{1'b1,1'b1,32'h50,W2, 1'b0,1'b0,Z,Z,  1'b1,1'b1,32'h50,W2, 2'b01,1'b0,1'b0,DB,R30},
      '{1'b1,1'b1,32'h50,W2, 1'b0,1'b0,Z,Z,  1'b0,1'b0,32'h50,W2, 2'b01,1'b1,1'b0,DB,R30},
      '{1'b0,1'b0,Z,Z,       1'b0,1'b0,Z,Z,  1'b0,1'b0,32'h50,W2, 2'b00,1'b0,1'b0,DB,R30}
    };

    rst = 1'b1;
    drive(1'b0, 1'b0, Z, Z, 1'b0, 1'b0, Z, Z);
    bus1.cpu_req = 1'b0; bus1.cpu_we = 1'b0; bus1.cpu_addr = Z; bus1.cpu_wdata = Z;
    bus1.dma_req = 1'b0; bus1.dma_we = 1'b0; bus1.dma_addr = Z; bus1.dma_wdata = Z;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Table: inputs held over one clock, outputs sampled on the following falling edge
    for (int i = 0; i < 24; i++) begin
      drive(vt[i].c_req, vt[i].c_we, vt[i].c_addr, vt[i].c_wd,
            vt[i].d_req, vt[i].d_we, vt[i].d_addr, vt[i].d_wd);
      @(negedge clk);
      chk($sformatf("v%0d.mem_en", i),    32'(bus.mem_en),    32'(vt[i].e_en));
      chk($sformatf("v%0d.mem_we", i),    32'(bus.mem_we),    32'(vt[i].e_we));
      chk($sformatf("v%0d.mem_addr", i),  bus.mem_addr,       vt[i].e_addr);
      chk($sformatf("v%0d.mem_wdata", i), bus.mem_wdata,      vt[i].e_wd);
      chk($sformatf("v%0d.grant", i),     32'(bus.grant_o),   32'(vt[i].e_gnt));
      chk($sformatf("v%0d.cpu_ready", i), 32'(bus.cpu_ready), 32'(vt[i].e_crdy));
      chk($sformatf("v%0d.dma_ready", i), 32'(bus.dma_ready), 32'(vt[i].e_drdy));
      chk($sformatf("v%0d.cpu_rdata", i), bus.cpu_rdata,      vt[i].e_crd);
      chk($sformatf("v%0d.dma_rdata", i), bus.dma_rdata,      vt[i].e_drd);
    end

    // Both requesters held high from reset
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h10, Z, 1'b1, 1'b0, 32'h60, Z);
    @(negedge clk);
    rst = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    n_cyc = 12;
`else
    n_cyc = 18;
`endif
    for (int c = 1; c <= n_cyc; c++) begin
      @(negedge clk);
      ph = (c - 1) % 4;
`ifdef ARB_FIXED_PRIO_EN
      own = 2'b01;
`else
      own = (((c - 1) / 4) % 2 == 0) ? 2'b01 : 2'b10;
`endif
      chk($sformatf("tie%0d.grant", c),     32'(bus.grant_o),   (ph == 3) ? Z : 32'(own));
      chk($sformatf("tie%0d.mem_en", c),    32'(bus.mem_en),    (ph < 2) ? 32'd1 : Z);
      chk($sformatf("tie%0d.mem_addr", c),  bus.mem_addr,       (own == 2'b01) ? 32'h10 : 32'h60);
      chk($sformatf("tie%0d.cpu_ready", c), 32'(bus.cpu_ready), (ph == 2 && own == 2'b01) ? 32'd1 : Z);
      chk($sformatf("tie%0d.dma_ready", c), 32'(bus.dma_ready), (ph == 2 && own == 2'b10) ? 32'd1 : Z);
    end
`ifdef ARB_FIXED_PRIO_EN
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("fixed.dma_grant", 32'(bus.grant_o), 32'd2);
    chk("fixed.dma_addr",  bus.mem_addr,     32'h60);
    @(negedge clk);
`endif

    // Reset in the second BUSY cycle abandons the access immediately
    chk("midrst.pre_en", 32'(bus.mem_en), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    drive(1'b0, 1'b0, Z, Z, 1'b0, 1'b0, Z, Z);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("post%0d.cpu_ready", c), 32'(bus.cpu_ready), Z);
      chk($sformatf("post%0d.dma_ready", c), 32'(bus.dma_ready), Z);
      chk($sformatf("post%0d.mem_en", c),    32'(bus.mem_en),    Z);
    end
    drive(1'b1, 1'b0, 32'h10, Z, 1'b1, 1'b0, 32'h60, Z);
    @(negedge clk);
    chk("post.tie_grant", 32'(bus.grant_o), 32'd1);
    drive(1'b0, 1'b0, Z, Z, 1'b0, 1'b0, Z, Z);
    @(negedge clk);
    @(negedge clk);
    chk("post.cpu_ready", 32'(bus.cpu_ready), 32'd1);
    chk("post.cpu_rdata", bus.cpu_rdata,      DB);
    @(negedge clk);

    // MEM_LAT=1 instance: a single BUSY cycle
    bus1.cpu_req = 1'b1; bus1.cpu_addr = 32'h10;
    @(negedge clk);
    chk("lat1.busy_en",    32'(bus1.mem_en),    32'd1);
    chk("lat1.busy_grant", 32'(bus1.grant_o),   32'd1);
    chk("lat1.busy_ready", 32'(bus1.cpu_ready), Z);
    @(negedge clk);
    bus1.cpu_req = 1'b0;
    chk("lat1.done_en",    32'(bus1.mem_en),    Z);
    chk("lat1.done_ready", 32'(bus1.cpu_ready), 32'd1);
    chk("lat1.rdata",      bus1.cpu_rdata,      DB);
    chk("lat1.dma_ready",  32'(bus1.dma_ready), Z);
    @(negedge clk);
    chk("lat1.idle_ready", 32'(bus1.cpu_ready), Z);
    chk("lat1.idle_grant", 32'(bus1.grant_o),   Z);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
